// File: rtl/lvds_pll_seq.sv
// -----------------------------------------------------------------------------
// lvds_pll_seq
//
// Brings up the clocking for an LVDS transmitter. The block resets the PLL,
// waits for it to lock, and checks that the lock stays high. It then releases
// the serializer/TX datapath. If lock does not arrive, it retries a limited
// number of times and then reports a failure.
//
// Parameters
//   RST_HOLD_CYC      cycles pll_reset is held per reset attempt (>= 2)
//   LOCK_STABLE_CYC   consecutive lock_s-high cycles required before RUN (>= 2)
//   LOCK_TIMEOUT_CYC  cycles spent waiting for lock per attempt (>= 4)
//   MAX_RETRY         retries allowed after the first attempt (0..15)
//
// Ports
//   clk            single clock for the whole block
//   rst_n          asynchronous active-low reset
//   enable         level request to bring TX clocking up; 0 returns to IDLE
//   pll_lock       PLL lock indicator, asynchronous to clk
//   pll_reset      active-high PLL reset (registered)
//   tx_rst_n       active-low serializer/TX reset (registered)
//   ready          TX clocking up and stable (registered)
//   fail           retries exhausted (registered)
//   retry_cnt      retries consumed in the current bring-up
//   lock_loss_cnt  number of lock losses seen in RUN, saturating at 255
//   state_dbg      current FSM state encoding, for observation only
//
// Handshake: there is no valid/ready transfer. enable is a level request, and
// ready is a level status that is high only while the FSM is in RUN.
//
// Configuration macro: LVDS_PLL_SEQ_LOSS_CNT_EN builds the lock-loss counter.
// When the macro is not defined, lock_loss_cnt is tied to zero.
// -----------------------------------------------------------------------------
module lvds_pll_seq #(
   parameter int RST_HOLD_CYC     = 16,
   parameter int LOCK_STABLE_CYC  = 1024,
   parameter int LOCK_TIMEOUT_CYC = 65536,
   parameter int MAX_RETRY        = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       tx_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_cnt,
   output logic [7:0] lock_loss_cnt,
   output logic [2:0] state_dbg
);

   // One shared timer serves the reset hold, the lock timeout and the stable
   // count. Only one of them is active in any state, so it is sized for the
   // largest of the three.
   localparam int MAX_AB  = (RST_HOLD_CYC > LOCK_STABLE_CYC) ? RST_HOLD_CYC : LOCK_STABLE_CYC;
   localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
   localparam int CW      = $clog2(MAX_CYC);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PLL_RST   = 3'd1,
      S_WAIT_LOCK = 3'd2,
      S_STABLE    = 3'd3,
      S_RUN       = 3'd4,
      S_FAIL      = 3'd5
   } state_t;

   state_t        state, next_state;
   logic [CW-1:0] timer, timer_nxt;
   logic [3:0]    retry_nxt;
   logic          lock_m, lock_s;

   // Two-flop synchronizer for the asynchronous lock input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   // Next-state and next-counter logic.
   always_comb begin
      next_state = state;
      timer_nxt  = timer;
      retry_nxt  = retry_cnt;
      if (!enable) begin
         next_state = S_IDLE;
         timer_nxt  = '0;
         retry_nxt  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               next_state = S_PLL_RST;
               timer_nxt  = '0;
               retry_nxt  = '0;
            end
            S_PLL_RST: begin
               if (timer == CW'(RST_HOLD_CYC - 1)) begin
                  next_state = S_WAIT_LOCK;
                  timer_nxt  = '0;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               // Lock is tested before the timeout, so lock wins when both
               // happen in the same cycle.
               if (lock_s) begin
                  next_state = S_STABLE;
                  timer_nxt  = '0;
               end else if (timer == CW'(LOCK_TIMEOUT_CYC - 1)) begin
                  timer_nxt = '0;
                  if (retry_cnt == 4'(MAX_RETRY)) begin
                     next_state = S_FAIL;
                  end else begin
                     next_state = S_PLL_RST;
                     retry_nxt  = retry_cnt + 4'd1;
                  end
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            S_STABLE: begin
               if (!lock_s) begin
                  next_state = S_WAIT_LOCK;
                  timer_nxt  = '0;
               end else if (timer == CW'(LOCK_STABLE_CYC - 1)) begin
                  next_state = S_RUN;
                  timer_nxt  = '0;
               end else begin
                  timer_nxt = timer + 1'b1;
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  next_state = S_PLL_RST;
                  timer_nxt  = '0;
                  retry_nxt  = '0;
               end
            end
            S_FAIL: begin
               next_state = S_FAIL;
            end
            default: begin
               next_state = S_IDLE;
               timer_nxt  = '0;
               retry_nxt  = '0;
            end
         endcase
      end
   end

   // State, counters and registered outputs. The outputs are decoded from
   // next_state, so they change on the same edge that the state changes.
   // For example, ready falls on the same edge that leaves RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         timer     <= '0;
         retry_cnt <= '0;
         pll_reset <= 1'b1;
         tx_rst_n  <= 1'b0;
         ready     <= 1'b0;
         fail      <= 1'b0;
      end else begin
         state     <= next_state;
         timer     <= timer_nxt;
         retry_cnt <= retry_nxt;
         pll_reset <= (next_state == S_IDLE) || (next_state == S_PLL_RST) ||
                      (next_state == S_FAIL);
         tx_rst_n  <= (next_state == S_RUN);
         ready     <= (next_state == S_RUN);
         fail      <= (next_state == S_FAIL);
      end
   end

`ifdef LVDS_PLL_SEQ_LOSS_CNT_EN
   logic [7:0] loss_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_q <= '0;
      end else if ((state == S_RUN) && (next_state == S_PLL_RST) && (loss_q != 8'hFF)) begin
         loss_q <= loss_q + 8'd1;
      end
   end

   assign lock_loss_cnt = loss_q;
`else
   assign lock_loss_cnt = 8'd0;
`endif

   assign state_dbg = state;

endmodule

// File: doc/lvds_pll_seq.md
LVDS_PLL_SEQ -- requirements
Module: lvds_pll_seq

Interface
REQ-001 SHALL have parameter RST_HOLD_CYC, default 16: cycles pll_reset is held high per reset attempt, minimum 2.
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 1024: consecutive synchronized lock-high cycles required before the TX is released, minimum 2.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYC, default 65536: maximum cycles spent waiting for lock per attempt, minimum 4.
REQ-004 SHALL have parameter MAX_RETRY, default 3: number of retries after the first attempt, range 0..15.
REQ-005 SHALL have port clk, input, 1 bit: single clock for the whole block.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: level request to bring the LVDS TX clocking up.
REQ-008 SHALL have port pll_lock, input, 1 bit: PLL lock, asynchronous to clk.
REQ-009 SHALL have port pll_reset, output, 1 bit: active-high PLL reset.
REQ-010 SHALL have port tx_rst_n, output, 1 bit: active-low reset for the serializer/TX datapath.
REQ-011 SHALL have port ready, output, 1 bit: TX clocking is up and stable.
REQ-012 SHALL have port fail, output, 1 bit: retries are exhausted.
REQ-013 SHALL have port retry_cnt, output, 4 bits: retries consumed in the current bring-up.
REQ-014 SHALL have port lock_loss_cnt, output, 8 bits: count of lock losses that occur in RUN.

Function
REQ-015 SHALL pass pll_lock through a 2-flop synchronizer (reset value 0), producing lock_s; all decisions use lock_s.
REQ-016 SHALL be implemented as an FSM with states IDLE, PLL_RST, WAIT_LOCK, STABLE, RUN and FAIL; all outputs SHALL be registered.
REQ-017 SHALL give enable=0 highest priority: from any state, the next state is IDLE.
REQ-018 IDLE: pll_reset=1, tx_rst_n=0, retry_cnt cleared; enable=1 moves to PLL_RST.
REQ-019 PLL_RST: pll_reset=1 for exactly RST_HOLD_CYC cycles, then move to WAIT_LOCK.
REQ-020 WAIT_LOCK: pll_reset=0 and the timeout timer counts from 0; lock_s=1 moves to STABLE.
REQ-021 WAIT_LOCK timeout: when the timer reaches LOCK_TIMEOUT_CYC-1 with lock_s=0, move to FAIL if retry_cnt==MAX_RETRY, else increment retry_cnt and move to PLL_RST.
REQ-022 STABLE: count consecutive lock_s=1 cycles; on reaching LOCK_STABLE_CYC, move to RUN; lock_s=0 clears the count and returns to WAIT_LOCK with the timeout timer restarted.
REQ-023 RUN: tx_rst_n=1 and ready=1; lock_s=0 moves to PLL_RST, increments lock_loss_cnt (saturating at 255) and clears retry_cnt.
REQ-024 On leaving RUN, ready SHALL fall and tx_rst_n SHALL assert in the same cycle the state leaves RUN.
REQ-025 FAIL: pll_reset=1, tx_rst_n=0, fail=1, retry_cnt holds; exit only via enable=0.
REQ-026 Outside RUN, ready=0 and tx_rst_n=0; outside FAIL, fail=0.
REQ-027 If lock_s timeout and lock_s=1 coincide in the same cycle, lock wins.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, pll_reset=1, tx_rst_n=0, ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0, all timers=0 and synchronizer=0.
REQ-029 Reset assertion mid-operation (any state) SHALL take effect immediately, with no completion of the pending sequence.

Configuration
REQ-030 With macro LVDS_PLL_SEQ_LOSS_CNT_EN defined, the lock-loss counter SHALL be implemented per REQ-023; without it, lock_loss_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification (RST_HOLD_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2)
REQ-031 Nominal bring-up: enable=1 with pll_lock rising 10 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; ready=1 and tx_rst_n=1 after 2 sync cycles plus 8 stable cycles; retry_cnt=0.
REQ-032 Retry exhaustion: enable=1, pll_lock held 0 -> three 4-cycle pll_reset pulses, each separated by 32 WAIT_LOCK cycles; retry_cnt=2 then fail=1; enable=0 -> IDLE and fail=0 next cycle.
REQ-033 Lock glitch during STABLE: lock drops for 1 cycle at stable count 5 -> no RUN; count restarts; RUN is entered only after 8 further consecutive cycles.
REQ-034 Lock loss in RUN: pll_lock drops -> ready=0 and tx_rst_n=0 on state exit; 4-cycle pll_reset; lock_loss_cnt=1 with macro defined, 0 without.
REQ-035 Async reset mid-WAIT_LOCK: rst_n pulsed low -> all outputs at REQ-028 values before the next clk edge; re-bring-up restarts from IDLE.
REQ-036 Saturation: 260 lock losses in RUN -> lock_loss_cnt=255.
